// File: rtl/lsu_bus_pkg.sv
// Shared state encodings and bus widths for the load/store bus controller.
package lsu_bus_pkg;

  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_BEW = BUS_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_bus.sv
// Load/store bus controller: one aligned access per request, valid/ready address phase then response phase.
// Optional response timeout is built only when LSU_BUS_TIMEOUT_EN is defined.
module lsu_bus
  import lsu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req,
  input  logic              i_store,
  input  logic [BUS_AW-1:0] i_addr,
  input  logic [BUS_DW-1:0] i_data_wr,
  input  logic [BUS_BEW-1:0] i_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [BUS_DW-1:0] o_data_rd,
  output logic              o_bus_valid,
  input  logic              i_bus_ready,
  output logic [BUS_AW-1:0] o_bus_addr,
  output logic [BUS_DW-1:0] o_bus_wdata,
  output logic [BUS_BEW-1:0] o_bus_we,
  output logic              o_bus_wr,
  input  logic              i_bus_rvalid,
  input  logic [BUS_DW-1:0] i_bus_rdata,
  input  logic              i_bus_err
);

  state_e               state_q, state_d;
  logic [BUS_AW-1:2]    addr_q, addr_d;
  logic [BUS_DW-1:0]    wdata_q, wdata_d;
  logic [BUS_BEW-1:0]   we_q, we_d;
  logic                 store_q, store_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [BUS_DW-1:0]    rdata_q, rdata_d;

  logic accept;
  logic bad_len;
  logic resp_fire;
  logic timeout;
  logic unused_addr_lsb;

  assign accept    = (state_q == ST_IDLE) && i_req;
  assign bad_len   = i_store && (i_we == '0);
  // A response in ADDR only counts when the address phase is accepted in the same cycle.
  assign resp_fire = ((state_q == ST_ADDR) && i_bus_ready && i_bus_rvalid) ||
                     ((state_q == ST_RESP) && i_bus_rvalid);
  assign unused_addr_lsb = ^i_addr[1:0];

`ifdef LSU_BUS_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_IDLE) cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Fires on the last waiting cycle so o_done lands TIMEOUT_CYCLES cycles after ADDR entry.
  assign timeout = (state_q != ST_IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_req && !bad_len) state_d = ST_ADDR;
      ST_ADDR: begin
        if (resp_fire || timeout) state_d = ST_IDLE;
        else if (i_bus_ready)     state_d = ST_RESP;
      end
      ST_RESP: if (resp_fire || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    store_d = store_q;
    rdata_d = rdata_q;
    if (accept && !bad_len) begin
      addr_d  = i_addr[BUS_AW-1:2];
      wdata_d = i_data_wr;
      we_d    = i_store ? i_we : '0;
      store_d = i_store;
    end
    done_d = (accept && bad_len) || resp_fire || timeout;
    err_d  = resp_fire ? i_bus_err : timeout;
    if (resp_fire && !store_q) rdata_d = i_bus_rdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= '0;
      store_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      store_q <= store_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_busy      = !i_rst && ((state_q != ST_IDLE) || i_req);
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_data_rd   = rdata_q;
  assign o_bus_valid = (state_q == ST_ADDR);
  assign o_bus_addr  = {addr_q, 2'b00};
  assign o_bus_wdata = wdata_q;
  assign o_bus_we    = we_q;
  assign o_bus_wr    = store_q;

endmodule
